// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: one-hot grant plus encoded winner ID, held until release.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_grant_scheduler #(
    parameter int N        = 16,
    parameter int IDW      = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    if ((N != (1 << IDW)) || (N < 2) || (N > 16) || (MAX_HOLD < 1)) begin : g_param_check
        $error("rr_grant_scheduler: inconsistent N/IDW/MAX_HOLD");
    end

    state_t         state_reg, state_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic [N-1:0]   gnt_reg, gnt_next;
    logic [IDW-1:0] id_reg, id_next;
    logic           valid_reg, valid_next;
    logic           timeout_reg, timeout_next;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    logic [HW-1:0] hold_reg, hold_next;
`endif

    // Requests rotated so bit 0 is the line just after the last winner.
    logic [N-1:0] rot_req;
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot_req[gi] = req[IDW'(ptr_reg + IDW'(gi + 1))];
    end

    logic [IDW-1:0] offset;
    logic           found;
    logic [IDW-1:0] winner;

    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                offset = IDW'(i);
                found  = 1'b1;
            end
        end
        winner = IDW'(ptr_reg + offset + IDW'(1));
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnt_next     = gnt_reg;
        id_next      = id_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_next    = hold_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (en && found) begin
                    gnt_next   = {{(N-1){1'b0}}, 1'b1} << winner;
                    id_next    = winner;
                    valid_next = 1'b1;
                    ptr_next   = winner;
                    state_next = BUSY;
`ifdef ARB_TIMEOUT_EN
                    hold_next  = '0;
`endif
                end
            end
            BUSY: begin
                if (!req[id_reg]) begin
                    gnt_next   = '0;
                    valid_next = 1'b0;
                    state_next = IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_reg == HOLD_LAST) begin
                    // Grant has now been visible MAX_HOLD cycles: force it off.
                    gnt_next     = '0;
                    valid_next   = 1'b0;
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    hold_next = hold_reg + HW'(1);
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= IDW'(N - 1);
            gnt_reg     <= '0;
            id_reg      <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_reg     <= gnt_next;
            id_reg      <= id_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
`ifdef ARB_TIMEOUT_EN
            hold_reg    <= hold_next;
`endif
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = id_reg;
    assign gnt_valid = valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: directed scenarios then random traffic against a queue-free model.
module tb_rr_grant_scheduler;

    localparam int N        = 16;
    localparam int IDW      = 4;
    localparam int MAX_HOLD = 15;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;

    rr_grant_scheduler #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: who owns the resource, how long, and who won last.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_held;
    bit m_to;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_edge(input logic r_n, input logic e, input logic [N-1:0] r);
        m_to = 1'b0;
        if (!r_n) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_last  = N - 1;
            m_held  = 0;
        end else if (m_busy) begin
            if (!r[m_owner]) m_busy = 1'b0;
            else if (TO_EN && m_held == MAX_HOLD) begin
                m_busy = 1'b0;
                m_to   = 1'b1;
            end else m_held++;
        end else if (e && r != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (r[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_busy  = 1'b1;
                    m_held  = 1;
                    break;
                end
            end
        end
    endtask

    // One clock: model sees the same inputs as the DUT, outputs compared 1 time unit later.
    task automatic step();
        logic [N-1:0] exp_gnt;
        @(posedge clk);
        model_edge(rst_n, en, req);
        #1;
        exp_gnt = m_busy ? (N'(1) << m_owner) : '0;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("gnt_id", 32'(gnt_id), 32'(m_owner));
        check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        check("timeout", 32'(timeout), 32'(m_to));
        $display("t=%0t rst_n=%b en=%b req=%h -> gnt=%h id=%0d v=%b to=%b",
                 $time, rst_n, en, req, gnt, gnt_id, gnt_valid, timeout);
    endtask

    int seq_exp [5] = '{0, 5, 10, 15, 0};

    initial begin
        // Reset with all lines requesting
        rst_n = 1'b0; en = 1'b1; req = 16'hFFFF;
        step(); step();
        check("reset_gnt", 32'(gnt), 32'h0);

        // Single requester
        rst_n = 1'b1; req = 16'h0010;
        step();
        check("single_id", 32'(gnt_id), 32'd4);
        req = 16'h0000;
        step();
        check("single_drop", 32'(gnt_valid), 32'd0);

        // Round robin 0,5,10,15,0 with one idle cycle between grants
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 16'h8421;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_id", 32'(gnt_id), 32'(seq_exp[i]));
            step();
            req = 16'h8421 & ~gnt;
            step();
            check("rr_idle", 32'(gnt_valid), 32'd0);
            req = 16'h8421;
        end

        // Wrap after 15 and enable gating
        req = 16'h8000; step(); req = 16'h0000; step();
        req = 16'h8001; step();
        check("wrap_id", 32'(gnt_id), 32'd0);
        req = 16'h0000; step();
        en = 1'b0; req = 16'h0100; step(); step();
        check("en0_idle", 32'(gnt_valid), 32'd0);
        en = 1'b1; step();
        en = 1'b0; step(); step();
        check("en0_busy", 32'(gnt), 32'h0100);
        en = 1'b1; req = 16'h0000; step();

        // Reset mid-grant
        req = 16'h0080; step();
        check("mid_id", 32'(gnt_id), 32'd7);
        rst_n = 1'b0; step();
        check("mid_rst", 32'(gnt_valid), 32'd0);
        rst_n = 1'b1; req = 16'h0081; step();
        check("post_rst_id", 32'(gnt_id), 32'd0);
        req = 16'h0000; step();

`ifdef ARB_TIMEOUT_EN
        begin
            int high_cycles;
            high_cycles = 0;
            req = 16'h0002; step();
            for (int i = 0; i < 40 && gnt_valid; i++) begin
                high_cycles++;
                step();
            end
            check("to_len", 32'(high_cycles), 32'(MAX_HOLD));
            check("to_pulse", 32'(timeout), 32'd1);
            step();
            check("to_regrant", 32'(gnt), 32'h0002);
            req = 16'h0000; step(); step();
        end
`endif

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [N-1:0] r;
            rst_n = ($urandom_range(0, 99) != 0);
            en    = ($urandom_range(0, 7) != 0);
            r     = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 5) == 0) r = '0;
            if (m_busy && $urandom_range(0, 9) != 0) r[m_owner] = 1'b1;
            req = r;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
